// File: rtl/wb_rr_arbiter_if.sv
// Bundle of the N-master Wishbone request side and the single shared slave side.
// The "slave" modport is the arbiter's view; "master" is the view of the surrounding system.
interface wb_rr_arbiter_if #(
  parameter int unsigned N_MASTER = 4
);
  logic [N_MASTER-1:0]    m_cyc_i;
  logic [N_MASTER-1:0]    m_stb_i;
  logic [N_MASTER-1:0]    m_we_i;
  logic [4*N_MASTER-1:0]  m_sel_i;
  logic [32*N_MASTER-1:0] m_adr_i;
  logic [32*N_MASTER-1:0] m_dat_i;
  logic [N_MASTER-1:0]    m_ack_o;
  logic [N_MASTER-1:0]    m_err_o;
  logic [31:0]            m_dat_o;
  logic                   s_cyc_o;
  logic                   s_stb_o;
  logic                   s_we_o;
  logic [3:0]             s_sel_o;
  logic [31:0]            s_adr_o;
  logic [31:0]            s_dat_o;
  logic                   s_ack_i;
  logic                   s_err_i;
  logic [31:0]            s_dat_i;
  logic [N_MASTER-1:0]    gnt_o;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
    input  s_ack_i, s_err_i, s_dat_i,
    output m_ack_o, m_err_o, m_dat_o,
    output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    output gnt_o
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
    output s_ack_i, s_err_i, s_dat_i,
    input  m_ack_o, m_err_o, m_dat_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    input  gnt_o
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: N masters share one slave, grant held for the whole CYC,
// with a per-grant watchdog that aborts an unanswered strobe and returns ERR to the owner.
module wb_rr_arbiter #(
  parameter int unsigned N_MASTER = 4,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic clk,
  input  logic rstn_i,
  wb_rr_arbiter_if.slave bus
);
  localparam int unsigned IW = $clog2(N_MASTER);
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, ABORT} state_t;

  state_t              state, state_nxt;
  logic [IW-1:0]       owner, owner_nxt;
  logic [IW-1:0]       last_owner, last_nxt;
  logic [N_MASTER-1:0] gnt, gnt_nxt;
  logic [CW-1:0]       wd_cnt, wd_nxt;

  logic [N_MASTER-1:0] req;
  logic [IW-1:0]       pick;
  logic                found;
  logic                own_cyc, own_stb;
  logic                resp;
  logic                tmo_c;

  assign req     = bus.m_cyc_i & bus.m_stb_i;
  assign own_cyc = bus.m_cyc_i[owner];
  assign own_stb = bus.m_stb_i[owner];
  assign resp    = bus.s_ack_i | bus.s_err_i;
  // A slave response in the expiry cycle wins over the watchdog.
  assign tmo_c   = (TIMEOUT != 0) && (state == GRANT) && own_cyc && own_stb && !resp
                   && (wd_cnt == CW'(TIMEOUT));

  // First requester after last_owner, with wrap-around.
  always_comb begin
    pick  = last_owner;
    found = 1'b0;
    for (int i = 1; i <= int'(N_MASTER); i++) begin
      if (!found && req[(int'(last_owner) + i) % int'(N_MASTER)]) begin
        pick  = IW'((int'(last_owner) + i) % int'(N_MASTER));
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= IW'(N_MASTER - 1);
      gnt        <= '0;
      wd_cnt     <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_nxt;
      gnt        <= gnt_nxt;
      wd_cnt     <= wd_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last_owner;
    gnt_nxt   = gnt;
    wd_nxt    = wd_cnt;
    unique case (state)
      IDLE: begin
        wd_nxt = '0;
        if (found) begin
          state_nxt = GRANT;
          owner_nxt = pick;
          gnt_nxt   = N_MASTER'(1) << pick;
        end
      end
      GRANT: begin
        if (!own_cyc) begin
          state_nxt = IDLE;
          last_nxt  = owner;
          gnt_nxt   = '0;
          wd_nxt    = '0;
        end else if (tmo_c) begin
          state_nxt = ABORT;
          wd_nxt    = '0;
        end else if (resp || !own_stb || (TIMEOUT == 0)) begin
          wd_nxt = '0;
        end else begin
          wd_nxt = wd_cnt + CW'(1);
        end
      end
      ABORT: begin
        wd_nxt = '0;
        if (!own_cyc) begin
          state_nxt = IDLE;
          last_nxt  = owner;
          gnt_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Owner's bus is steered to the slave only while granted; response routed back to owner only.
  always_comb begin
    bus.s_cyc_o = 1'b0;
    bus.s_stb_o = 1'b0;
    bus.s_we_o  = 1'b0;
    bus.s_sel_o = '0;
    bus.s_adr_o = '0;
    bus.s_dat_o = '0;
    bus.m_ack_o = '0;
    bus.m_err_o = '0;
    if (state == GRANT) begin
      bus.s_cyc_o = own_cyc;
      bus.s_stb_o = own_stb;
      bus.s_we_o  = bus.m_we_i[owner];
      bus.s_sel_o = bus.m_sel_i[4*int'(owner) +: 4];
      bus.s_adr_o = bus.m_adr_i[32*int'(owner) +: 32];
      bus.s_dat_o = bus.m_dat_i[32*int'(owner) +: 32];
      bus.m_ack_o[owner] = bus.s_ack_i;
      bus.m_err_o[owner] = bus.s_err_i | tmo_c;
    end
  end

  assign bus.m_dat_o = bus.s_dat_i;
  assign bus.gnt_o   = gnt;
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter (N=4, T=16) with a scoreboard queue of expected results.
module tb_wb_rr_arbiter;
  localparam int unsigned N = 4;
  localparam int unsigned T = 16;

  logic clk;
  logic rstn;
  int   n_cmp;
  int   n_err;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;
  exp_t sb_q[$];

  wb_rr_arbiter_if #(.N_MASTER(N)) bus ();

  wb_rr_arbiter #(.N_MASTER(N), .TIMEOUT(T)) dut (
    .clk    (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time bound exceeded");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic pop_chk(input logic [63:0] obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("sb_underflow", 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      chk(e.tag, obs, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_m(input int k, input logic cyc, input logic stb, input logic we,
                       input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
    bus.m_cyc_i[k] = cyc;
    bus.m_stb_i[k] = stb;
    bus.m_we_i[k]  = we;
    bus.m_sel_i[4*k +: 4]   = sel;
    bus.m_adr_i[32*k +: 32] = adr;
    bus.m_dat_i[32*k +: 32] = dat;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    bus.m_cyc_i = '0;
    bus.m_stb_i = '0;
    bus.m_we_i  = '0;
    bus.m_sel_i = '0;
    bus.m_adr_i = '0;
    bus.m_dat_i = '0;
    bus.s_ack_i = 1'b0;
    bus.s_err_i = 1'b0;
    bus.s_dat_i = '0;
    tick();
    tick();
    @(negedge clk);
    rstn = 1'b1;
    tick();
  endtask

  logic [N-1:0] exp_g;
  logic [N-1:0] seen_err;

  initial begin
    n_cmp = 0;
    n_err = 0;
    do_reset();

    // Reset state
    chk("rst_gnt", 64'(bus.gnt_o), 64'd0);
    chk("rst_scyc", 64'({bus.s_cyc_o, bus.s_stb_o, bus.s_we_o}), 64'd0);
    chk("rst_ackerr", 64'({bus.m_ack_o, bus.m_err_o}), 64'd0);

    // Single request: master 2 read, ack after 3 cycles
    set_m(2, 1, 1, 0, 4'hF, 32'h0000_0810, 32'h0);
    push("single_data", 64'hDEAD_BEEF);
    settle();
    chk("single_gnt_pre", 64'(bus.gnt_o), 64'd0);
    tick();
    chk("single_gnt", 64'(bus.gnt_o), 64'b0100);
    chk("single_adr", 64'(bus.s_adr_o), 64'h810);
    chk("single_stb", 64'({bus.s_cyc_o, bus.s_stb_o}), 64'b11);
    tick();
    tick();
    chk("single_noack", 64'(bus.m_ack_o), 64'd0);
    tick();
    bus.s_ack_i = 1'b1;
    bus.s_dat_i = 32'hDEAD_BEEF;
    settle();
    chk("single_ack", 64'(bus.m_ack_o), 64'b0100);
    pop_chk(64'(bus.m_dat_o));
    tick();
    bus.s_ack_i = 1'b0;
    set_m(2, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    settle();
    chk("single_ack_clr", 64'(bus.m_ack_o), 64'd0);
    tick();
    chk("single_release", 64'(bus.gnt_o), 64'd0);

    // Fairness: all four request continuously, order 0,1,2,3,0 from reset
    do_reset();
    for (int k = 0; k < 4; k++) set_m(k, 1, 1, 0, 4'hF, 32'(k * 16), 32'h0);
    push("fair_g0", 64'b0001);
    push("fair_g1", 64'b0010);
    push("fair_g2", 64'b0100);
    push("fair_g3", 64'b1000);
    push("fair_g4", 64'b0001);
    tick();
    for (int r = 0; r < 5; r++) begin
      exp_g = bus.gnt_o;
      pop_chk(64'(bus.gnt_o));
      bus.s_ack_i = 1'b1;
      settle();
      chk("fair_ack_owner_only", 64'(bus.m_ack_o), 64'(exp_g));
      for (int k = 0; k < 4; k++) if (exp_g[k]) set_m(k, 0, 0, 0, 4'hF, 32'(k * 16), 32'h0);
      bus.s_ack_i = 1'b0;
      tick();
      chk("fair_dead_gnt", 64'(bus.gnt_o), 64'd0);
      chk("fair_dead_ack", 64'(bus.m_ack_o), 64'd0);
      for (int k = 0; k < 4; k++) set_m(k, 1, 1, 0, 4'hF, 32'(k * 16), 32'h0);
      tick();
    end
    for (int k = 0; k < 4; k++) set_m(k, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    tick();
    tick();

    // Grant hold: master 1 bursts 4 strobes while master 3 waits (last_owner=0 here)
    set_m(1, 1, 1, 0, 4'hF, 32'h100, 32'h0);
    tick();
    chk("hold_gnt1", 64'(bus.gnt_o), 64'b0010);
    set_m(3, 1, 1, 1, 4'h3, 32'h300, 32'h3333);
    for (int p = 0; p < 4; p++) begin
      set_m(1, 1, 1, 0, 4'hF, 32'h100 + 32'(p * 4), 32'h0);
      bus.s_ack_i = 1'b1;
      push("hold_ack", 64'b0010);
      settle();
      pop_chk(64'(bus.m_ack_o));
      tick();
      bus.s_ack_i = 1'b0;
      set_m(1, 1, 0, 0, 4'hF, 32'h100, 32'h0);
      settle();
      chk("hold_gnt_kept", 64'(bus.gnt_o), 64'b0010);
      tick();
    end
    set_m(1, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    tick();
    chk("hold_dead", 64'(bus.gnt_o), 64'd0);
    tick();
    chk("hold_gnt3", 64'(bus.gnt_o), 64'b1000);
    set_m(3, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    tick();
    tick();

    // Timeout: master 0 strobes, slave silent; master 1 waiting
    do_reset();
    set_m(0, 1, 1, 0, 4'hF, 32'h40, 32'h0);
    tick();
    chk("tmo_gnt0", 64'(bus.gnt_o), 64'b0001);
    set_m(1, 1, 1, 0, 4'hF, 32'h44, 32'h0);
    seen_err = '0;
    for (int c = 1; c <= int'(T); c++) begin
      settle();
      seen_err = seen_err | bus.m_err_o;
      tick();
    end
    chk("tmo_no_early_err", 64'(seen_err), 64'd0);
    chk("tmo_err", 64'(bus.m_err_o), 64'b0001);
    tick();
    chk("tmo_abort_scyc", 64'({bus.s_cyc_o, bus.s_stb_o}), 64'd0);
    chk("tmo_abort_err", 64'(bus.m_err_o), 64'd0);
    chk("tmo_abort_gnt", 64'(bus.gnt_o), 64'b0001);
    tick();
    set_m(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    tick();
    chk("tmo_idle", 64'(bus.gnt_o), 64'd0);
    tick();
    chk("tmo_gnt1", 64'(bus.gnt_o), 64'b0010);
    set_m(1, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    tick();
    tick();

    // Slave ERR on master 3 write; grant held until CYC drops (last_owner=1)
    set_m(3, 1, 1, 1, 4'h5, 32'h0000_0C00, 32'hCAFE_F00D);
    tick();
    chk("err_gnt3", 64'(bus.gnt_o), 64'b1000);
    chk("err_wbus", {bus.s_we_o, 3'b0, bus.s_sel_o, bus.s_dat_o, 24'h0}, {1'b1, 3'b0, 4'h5, 32'hCAFE_F00D, 24'h0});
    tick();
    bus.s_err_i = 1'b1;
    push("err_route", 64'b1000);
    settle();
    pop_chk(64'(bus.m_err_o));
    chk("err_noack", 64'(bus.m_ack_o), 64'd0);
    tick();
    bus.s_err_i = 1'b0;
    set_m(3, 1, 0, 1, 4'h5, 32'h0000_0C00, 32'hCAFE_F00D);
    seen_err = '0;
    for (int c = 0; c < int'(T) + 4; c++) begin
      settle();
      seen_err = seen_err | bus.m_err_o;
      tick();
    end
    chk("err_no_tmo", 64'(seen_err), 64'd0);
    chk("err_held", 64'({bus.gnt_o, 3'b0, bus.s_cyc_o}), 64'({4'b1000, 3'b0, 1'b1}));
    set_m(3, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    tick();
    chk("err_release", 64'(bus.gnt_o), 64'd0);

    // Reset mid-burst while master 2 owns the bus (last_owner=3)
    set_m(2, 1, 1, 0, 4'hF, 32'h200, 32'h0);
    tick();
    chk("rstmid_gnt2", 64'(bus.gnt_o), 64'b0100);
    set_m(0, 1, 1, 0, 4'hF, 32'h0, 32'h0);
    tick();
    rstn = 1'b0;
    settle();
    chk("rstmid_gnt", 64'(bus.gnt_o), 64'd0);
    chk("rstmid_scyc", 64'(bus.s_cyc_o), 64'd0);
    tick();
    @(negedge clk);
    rstn = 1'b1;
    tick();
    chk("rstmid_prio0", 64'(bus.gnt_o), 64'b0001);

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
